// File: rtl/display_scan_ctrl.sv
// Four-digit 7-segment scan controller with blanking gaps and frame-boundary shadow loads.
// Optional digit blinking is enabled by defining DISPLAY_SCAN_BLINK_EN.
module display_scan_ctrl #(
   parameter int DWELL_CYC    = 50000,
   parameter int BLANK_CYC    = 16
`ifdef DISPLAY_SCAN_BLINK_EN
   ,
   parameter int BLINK_FRAMES = 64
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [2:0] code0,
   input  logic [2:0] code1,
   input  logic [2:0] code2,
   input  logic [2:0] code3,
   input  logic [3:0] dig_en,
   input  logic       upd_req,
`ifdef DISPLAY_SCAN_BLINK_EN
   input  logic [3:0] blink_mask,
`endif
   output logic       upd_ack,
   output logic [2:0] seg_code,
   output logic [3:0] an,
   output logic       frame_tick
);

   localparam int MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
   localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BLANK = 2'd1;
   localparam logic [1:0] ST_DRIVE = 2'd2;

   logic [1:0]    r_state;
   logic [1:0]    r_slot;
   logic [CW-1:0] r_cnt;
   logic [11:0]   r_sh_code;
   logic [3:0]    r_sh_en;
   logic [3:0]    r_an;
   logic [2:0]    r_seg_code;
   logic          r_upd_ack;
   logic          r_frame_tick;

   logic [1:0]    w_state_nxt;
   logic [1:0]    w_slot_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_tick_nxt;
   logic          w_load;
   logic [11:0]   w_code_nxt;
   logic [2:0]    w_seg_nxt;
   logic [3:0]    w_blink_mask;
   logic          w_drive_on;

   function automatic logic [3:0] anode_drive(input logic [1:0] slot, input logic on);
      logic [3:0] v;
      v = 4'b1111;
      if (on) begin
         v[slot] = 1'b0;
      end else begin
         v = 4'b1111;
      end
      return v;
   endfunction

   // Scan sequencing: IDLE -> BLANK -> DRIVE per slot, dropping to IDLE whenever en is low
   always_comb begin
      w_state_nxt = r_state;
      w_slot_nxt  = r_slot;
      w_cnt_nxt   = r_cnt;
      if (!en) begin
         w_state_nxt = ST_IDLE;
         w_slot_nxt  = 2'd0;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_BLANK;
               w_slot_nxt  = 2'd0;
               w_cnt_nxt   = '0;
            end
            ST_BLANK: begin
               if (r_cnt == BLANK_LAST) begin
                  w_state_nxt = ST_DRIVE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt   = r_cnt + CW'(1);
               end
            end
            ST_DRIVE: begin
               if (r_cnt == DWELL_LAST) begin
                  w_state_nxt = ST_BLANK;
                  w_slot_nxt  = r_slot + 2'd1;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt   = r_cnt + CW'(1);
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_slot_nxt  = 2'd0;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Outputs are registered from next-state values, so the tick marks the final DIG3 drive cycle
   assign w_tick_nxt = (w_state_nxt == ST_DRIVE) && (w_slot_nxt == 2'd3) && (w_cnt_nxt == DWELL_LAST);
   assign w_load     = upd_req && !r_upd_ack && ((r_state == ST_IDLE) || w_tick_nxt);
   assign w_code_nxt = w_load ? {code3, code2, code1, code0} : r_sh_code;

   // Decoder input for the slot being entered
   always_comb begin
      w_seg_nxt = 3'b000;
      case (w_slot_nxt)
         2'd0:    w_seg_nxt = w_code_nxt[2:0];
         2'd1:    w_seg_nxt = w_code_nxt[5:3];
         2'd2:    w_seg_nxt = w_code_nxt[8:6];
         2'd3:    w_seg_nxt = w_code_nxt[11:9];
         default: w_seg_nxt = 3'b000;
      endcase
   end

`ifdef DISPLAY_SCAN_BLINK_EN
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

   logic [FW-1:0] r_frm_cnt;
   logic          r_blink_ph;

   // Blink phase toggles every BLINK_FRAMES frame ticks; starts visible
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frm_cnt  <= '0;
         r_blink_ph <= 1'b0;
      end else if (w_tick_nxt) begin
         if (r_frm_cnt == FRM_LAST) begin
            r_frm_cnt  <= '0;
            r_blink_ph <= ~r_blink_ph;
         end else begin
            r_frm_cnt  <= r_frm_cnt + FW'(1);
         end
      end
   end

   assign w_blink_mask = r_blink_ph ? blink_mask : 4'b0000;
`else
   assign w_blink_mask = 4'b0000;
`endif

   // Current shadow enables are used so a frame-boundary load cannot alter the last DIG3 cycle
   assign w_drive_on = (w_state_nxt == ST_DRIVE) && r_sh_en[w_slot_nxt] && !w_blink_mask[w_slot_nxt];

   // State, shadow registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_slot       <= 2'd0;
         r_cnt        <= '0;
         r_sh_code    <= 12'h000;
         r_sh_en      <= 4'b0000;
         r_an         <= 4'b1111;
         r_seg_code   <= 3'b000;
         r_upd_ack    <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_slot       <= w_slot_nxt;
         r_cnt        <= w_cnt_nxt;
         r_upd_ack    <= w_load;
         r_frame_tick <= w_tick_nxt;
         r_an         <= anode_drive(w_slot_nxt, w_drive_on);
         if (w_load) begin
            r_sh_code <= {code3, code2, code1, code0};
            r_sh_en   <= dig_en;
         end
         if (w_state_nxt == ST_BLANK) begin
            r_seg_code <= w_seg_nxt;
         end
      end
   end

   assign an         = r_an;
   assign seg_code   = r_seg_code;
   assign upd_ack    = r_upd_ack;
   assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a frame-position reference model.
// Exercises blinking too when DISPLAY_SCAN_BLINK_EN is defined.
module tb_display_scan_ctrl;

   localparam int DW    = 4;
   localparam int BL    = 2;
   localparam int SLOTC = DW + BL;
   localparam int FRAME = 4 * SLOTC;
   localparam int BF    = 2;

   logic       clk = 1'b0;
   logic       rst_n, en, upd_req;
   logic [2:0] code0, code1, code2, code3;
   logic [3:0] dig_en;
   logic       upd_ack, frame_tick;
   logic [2:0] seg_code;
   logic [3:0] an;
`ifdef DISPLAY_SCAN_BLINK_EN
   logic [3:0] blink_mask;
`endif

   always #5 clk = ~clk;

   display_scan_ctrl #(
      .DWELL_CYC(DW),
      .BLANK_CYC(BL)
`ifdef DISPLAY_SCAN_BLINK_EN
      ,
      .BLINK_FRAMES(BF)
`endif
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .code0(code0),
      .code1(code1),
      .code2(code2),
      .code3(code3),
      .dig_en(dig_en),
      .upd_req(upd_req),
`ifdef DISPLAY_SCAN_BLINK_EN
      .blink_mask(blink_mask),
`endif
      .upd_ack(upd_ack),
      .seg_code(seg_code),
      .an(an),
      .frame_tick(frame_tick)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int last_tick = -1;

   // Reference model: position within the frame since the scan (re)started
   bit         m_run;
   int         m_pos;
   logic [2:0] m_sh_code [4];
   logic [2:0] m_frame_code [4];
   logic [3:0] m_sh_en;
   logic       m_ack, m_tick;
   logic [3:0] m_an;
   logic [2:0] m_seg;
   int         m_fcnt;
   bit         m_bph;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 1'b0; m_pos = 0; m_sh_en = 4'b0000;
      m_ack = 1'b0; m_tick = 1'b0; m_an = 4'b1111; m_seg = 3'b000;
      m_fcnt = 0; m_bph = 1'b0;
      for (int k = 0; k < 4; k++) begin
         m_sh_code[k] = 3'b000;
         m_frame_code[k] = 3'b000;
      end
   endtask

   task automatic model_step();
      bit         was_idle = !m_run;
      logic       prev_ack = m_ack;
      int         slot;
      logic [3:0] bm = 4'b0000;
      if (!en) begin
         m_run = 1'b0; m_pos = 0;
      end else if (!m_run) begin
         m_run = 1'b1; m_pos = 0;
      end else begin
         m_pos = (m_pos + 1) % FRAME;
      end
      m_tick = m_run && (m_pos == FRAME - 1);
      slot = m_pos / SLOTC;
`ifdef DISPLAY_SCAN_BLINK_EN
      bm = m_bph ? blink_mask : 4'b0000;
`endif
      m_an = 4'b1111;
      if (m_run && (m_pos % SLOTC) >= BL && m_sh_en[slot] && !bm[slot]) m_an[slot] = 1'b0;
      m_ack = upd_req && !prev_ack && (was_idle || m_tick);
      if (m_ack) begin
         m_sh_code[0] = code0; m_sh_code[1] = code1;
         m_sh_code[2] = code2; m_sh_code[3] = code3;
         m_sh_en = dig_en;
      end
      if (m_run && m_pos == 0) m_frame_code = m_sh_code;
      if (m_run) m_seg = m_frame_code[slot];
`ifdef DISPLAY_SCAN_BLINK_EN
      if (m_tick) begin
         m_fcnt++;
         if (m_fcnt == BF) begin
            m_fcnt = 0;
            m_bph = !m_bph;
         end
      end
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc++;
      check_val("an", an, m_an);
      check_val("seg_code", seg_code, m_seg);
      check_val("upd_ack", upd_ack, m_ack);
      check_val("frame_tick", frame_tick, m_tick);
      if (!en) begin
         last_tick = -1;
      end else if (frame_tick === 1'b1) begin
         if (last_tick >= 0) check_val("frame_period", cyc - last_tick, FRAME);
         last_tick = cyc;
      end
      if (upd_req && m_ack) upd_req = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_to_pos(input int p);
      int guard = 0;
      while ((!m_run || m_pos != p) && guard < 4 * FRAME) begin
         step();
         guard++;
      end
      check_val("wait_pos", m_pos, p);
   endtask

   task automatic request(input logic [2:0] c0, input logic [2:0] c1,
                          input logic [2:0] c2, input logic [2:0] c3, input logic [3:0] de);
      code0 = c0; code1 = c1; code2 = c2; code3 = c3; dig_en = de; upd_req = 1'b1;
   endtask

   task automatic rand_cycle();
      if ($urandom_range(0, 199) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      if (!upd_req && $urandom_range(0, 29) == 0)
         request(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 4'($urandom));
      if ($urandom_range(0, 9) == 0) begin
         case ($urandom_range(0, 4))
            0: code0 = 3'($urandom);
            1: code1 = 3'($urandom);
            2: code2 = 3'($urandom);
            3: code3 = 3'($urandom);
            default: dig_en = 4'($urandom);
         endcase
      end
`ifdef DISPLAY_SCAN_BLINK_EN
      if ($urandom_range(0, 99) == 0) blink_mask = 4'($urandom);
`endif
      step();
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; upd_req = 1'b0;
      code0 = 3'd0; code1 = 3'd0; code2 = 3'd0; code3 = 3'd0; dig_en = 4'b0000;
`ifdef DISPLAY_SCAN_BLINK_EN
      blink_mask = 4'b0000;
`endif
      model_reset();
      @(posedge clk); #1;
      check_val("rst_an", an, 4'b1111);
      check_val("rst_seg", seg_code, 3'b000);
      check_val("rst_ack", upd_ack, 1'b0);
      check_val("rst_tick", frame_tick, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Disabled display stays dark
      run(10);

      // IDLE load then one full scan sequence
      en = 1'b1;
      request(3'd1, 3'd2, 3'd3, 3'd4, 4'b1111);
      run(3 * FRAME);

      // Mid-frame code change only lands at the frame boundary
      run_to_pos(8);
      request(3'd1, 3'd2, 3'd7, 3'd4, 4'b1111);
      run(2 * FRAME);

      // Disabled digits keep their slot timing
      request(3'd1, 3'd2, 3'd7, 3'd4, 4'b1010);
      run(3 * FRAME);

      // Drop enable during slot-2 drive, then restart
      request(3'd5, 3'd6, 3'd7, 3'd0, 4'b1111);
      run(2 * FRAME);
      run_to_pos(14);
      en = 1'b0;
      step();
      check_val("an_after_drop", an, 4'b1111);
      run(3);
      en = 1'b1;
      run(2 * FRAME);

`ifdef DISPLAY_SCAN_BLINK_EN
      blink_mask = 4'b0001;
`endif
      run(6 * FRAME);

      for (int i = 0; i < 3000; i++) rand_cycle();

      // Asynchronous reset in the middle of a frame with a request pending
      en = 1'b1;
      run_to_pos(10);
      request(3'd3, 3'd3, 3'd3, 3'd3, 4'b0110);
      rst_n = 1'b0;
      #1;
      check_val("midrst_an", an, 4'b1111);
      check_val("midrst_seg", seg_code, 3'b000);
      check_val("midrst_ack", upd_ack, 1'b0);
      check_val("midrst_tick", frame_tick, 1'b0);
      model_reset();
      last_tick = -1;
      @(negedge clk);
      rst_n = 1'b1;
      run(2 * FRAME);
      for (int i = 0; i < 500; i++) rand_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
